// File: rtl/mmm_out_framer_if.sv
`timescale 1ns/1ps
`default_nettype none
// mmm_out_framer_if: input result stream and framed output stream of the output framer.
interface mmm_out_framer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  IN_TDATA;
  logic             IN_TVALID;
  logic             IN_TREADY;
  logic [OUT_W-1:0] OUT_TDATA;
  logic             OUT_TVALID;
  logic             OUT_TREADY;
  logic             OUT_TLAST;
  logic [1:0]       OUT_TUSER;

  modport slave (
    input  IN_TDATA, IN_TVALID, OUT_TREADY,
    output IN_TREADY, OUT_TDATA, OUT_TVALID, OUT_TLAST, OUT_TUSER
  );

  modport master (
    output IN_TDATA, IN_TVALID, OUT_TREADY,
    input  IN_TREADY, OUT_TDATA, OUT_TVALID, OUT_TLAST, OUT_TUSER
  );
endinterface
`default_nettype wire

// File: rtl/mmm_out_framer.sv
`timescale 1ns/1ps
`default_nettype none
// mmm_out_framer: saturates matrix-multiply results to OUT_W bits, adds row/matrix framing,
// and buffers them in a 2-entry skid buffer with a registered input ready.
module mmm_out_framer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int M     = 7,
  parameter int N     = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  mmm_out_framer_if.slave  bus,
  output logic [CNT_W-1:0] sat_count
);
  localparam int c_col_w = (N > 1) ? $clog2(N) : 1;
  localparam int c_row_w = (M > 1) ? $clog2(M) : 1;
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(N - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(M - 1);
  localparam logic signed [IN_W-1:0] c_sat_max = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] c_sat_min = ~c_sat_max;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             row_end;
    logic             last;
    logic             sat;
  } entry_t;

  entry_t               buf_q [2];
  entry_t               entry_d;
  entry_t               head;
  logic [1:0]           occ_q, occ_d;
  logic                 head_q, head_d;
  logic                 in_ready_q, in_ready_d;
  logic [c_col_w-1:0]   col_q, col_d;
  logic [c_row_w-1:0]   row_q, row_d;
  logic [CNT_W-1:0]     sat_count_q, sat_count_d;
  logic                 accept, xfer, tail, col_end;
  logic signed [IN_W-1:0] x;

  assign accept  = bus.IN_TVALID && in_ready_q;
  assign xfer    = (occ_q != 2'd0) && bus.OUT_TREADY;
  // With one entry held the free slot is the one after the head; with none it is the head.
  assign tail    = head_q ^ occ_q[0];
  assign col_end = (col_q == c_col_last);
  assign x       = signed'(bus.IN_TDATA);

  always_comb begin
    entry_d = '0;
    if (x > c_sat_max) begin
      entry_d.data = c_sat_max[OUT_W-1:0];
      entry_d.sat  = 1'b1;
    end else if (x < c_sat_min) begin
      entry_d.data = c_sat_min[OUT_W-1:0];
      entry_d.sat  = 1'b1;
    end else begin
      entry_d.data = bus.IN_TDATA[OUT_W-1:0];
    end
    entry_d.row_end = col_end;
    entry_d.last    = col_end && (row_q == c_row_last);
  end

  always_comb begin
    occ_d       = occ_q + 2'(accept) - 2'(xfer);
    head_d      = head_q ^ xfer;
    in_ready_d  = (occ_d != 2'd2);
    col_d       = col_q;
    row_d       = row_q;
    sat_count_d = sat_count_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = (row_q == c_row_last) ? '0 : row_q + c_row_w'(1);
      end else begin
        col_d = col_q + c_col_w'(1);
      end
      if (entry_d.sat && (sat_count_q != '1)) begin
        sat_count_d = sat_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      occ_q       <= '0;
      head_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      sat_count_q <= '0;
    end else begin
      if (accept) begin
        buf_q[tail] <= entry_d;
      end
      occ_q       <= occ_d;
      head_q      <= head_d;
      in_ready_q  <= in_ready_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign head           = buf_q[head_q];
  assign bus.IN_TREADY  = in_ready_q;
  assign bus.OUT_TVALID = (occ_q != 2'd0);
  assign bus.OUT_TDATA  = head.data;
  assign bus.OUT_TLAST  = head.last;
  assign bus.OUT_TUSER  = {head.sat, head.row_end};
  assign sat_count      = sat_count_q;
endmodule
`default_nettype wire

// File: tb/tb_mmm_out_framer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mmm_out_framer: randomized and directed stimulus against a queue-based reference model.
module tb_mmm_out_framer;
  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int M     = 2;
  localparam int N     = 3;
  localparam int CNT_W = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic [CNT_W-1:0] sat_count;

  mmm_out_framer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  mmm_out_framer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .M(M), .N(N), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [1:0]       user;
    logic             last;
  } exp_t;

  exp_t            exp_q[$];
  logic [IN_W-1:0] pend_q[$];
  int              acc_idx;
  int              sat_model;
  int              n_chk;
  int              n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: element k since reset sits at position k mod M*N of its matrix.
  function automatic void model_accept(input logic [IN_W-1:0] x);
    longint hi  = (longint'(1) << (OUT_W - 1)) - 1;
    longint lo  = -(longint'(1) << (OUT_W - 1));
    longint sx  = longint'($signed(x));
    int     pos = acc_idx % (M * N);
    exp_t   e;
    logic   sat = 1'b0;
    if (sx > hi) begin
      e.d = OUT_W'(hi); sat = 1'b1;
    end else if (sx < lo) begin
      e.d = OUT_W'(lo); sat = 1'b1;
    end else begin
      e.d = x[OUT_W-1:0];
    end
    e.user = {sat, (pos % N) == N - 1};
    e.last = (pos == M * N - 1);
    exp_q.push_back(e);
    acc_idx++;
    if (sat && sat_model < (1 << CNT_W) - 1) sat_model++;
  endfunction

  function automatic logic [IN_W-1:0] rand_data();
    case ($urandom_range(3))
      0:       return $urandom;
      1:       return IN_W'($urandom_range(255)) - IN_W'(128);
      2:       return IN_W'($urandom_range(400)) - IN_W'(200);
      default: return {IN_W{$urandom_range(1) == 1}} ^ IN_W'($urandom_range(130, 126));
    endcase
  endfunction

  // One clock cycle: called and returns on a falling edge.
  task automatic step(input int vld_pct, input int rdy_pct);
    bus.IN_TVALID  = (pend_q.size() != 0) && ($urandom_range(99) < vld_pct);
    bus.IN_TDATA   = (pend_q.size() != 0) ? pend_q[0] : $urandom;
    bus.OUT_TREADY = ($urandom_range(99) < rdy_pct);
    #1;
    check_eq("out_tvalid", bus.OUT_TVALID, exp_q.size() != 0);
    check_eq("in_tready", bus.IN_TREADY, exp_q.size() < 2);
    if (bus.OUT_TVALID && exp_q.size() != 0) begin
      check_eq("out_tdata", bus.OUT_TDATA, exp_q[0].d);
      check_eq("out_tuser", bus.OUT_TUSER, exp_q[0].user);
      check_eq("out_tlast", bus.OUT_TLAST, exp_q[0].last);
      if (bus.OUT_TREADY) void'(exp_q.pop_front());
    end
    if (bus.IN_TVALID && bus.IN_TREADY) begin
      model_accept(pend_q.pop_front());
    end
    @(negedge clk);
    check_eq("sat_count", sat_count, sat_model);
  endtask

  task automatic run_to_drain(input int vp, input int rp, input string tag, input int limit);
    int n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      step(vp, rp);
      n++;
    end
    check_eq({tag, "_drained"}, pend_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.IN_TVALID  = 1'b0;
    bus.OUT_TREADY = 1'b0;
    #1;
    check_eq("rst_out_tvalid", bus.OUT_TVALID, 0);
    check_eq("rst_in_tready", bus.IN_TREADY, 0);
    check_eq("rst_out_tdata", bus.OUT_TDATA, 0);
    check_eq("rst_out_tlast", bus.OUT_TLAST, 0);
    check_eq("rst_out_tuser", bus.OUT_TUSER, 0);
    check_eq("rst_sat_count", sat_count, 0);
    exp_q.delete();
    pend_q.delete();
    acc_idx   = 0;
    sat_model = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.IN_TVALID  = 1'b0;
    bus.IN_TDATA   = '0;
    bus.OUT_TREADY = 1'b0;
    @(negedge clk);

    // Two full matrices back-to-back at full rate.
    do_reset();
    for (int k = 0; k < 12; k++) pend_q.push_back(IN_W'(k));
    run_to_drain(100, 100, "framing", 100);

    // Saturation corners; the 2-bit counter clips at 3.
    do_reset();
    pend_q = '{32'd127, 32'd128, -32'sd128, -32'sd129, 32'h7FFF_FFFF, 32'h8000_0000};
    run_to_drain(100, 100, "sat", 100);
    check_eq("sat_clipped", sat_count, 3);

    // Backpressure: four offered, only two fit.
    do_reset();
    for (int k = 0; k < 4; k++) pend_q.push_back(IN_W'(40 + k));
    repeat (4) step(100, 0);
    check_eq("bp_accepted", 4 - pend_q.size(), 2);
    check_eq("bp_in_tready", bus.IN_TREADY, 0);
    run_to_drain(100, 100, "bp", 100);

    // Random handshakes, framing continues from the previous stream.
    for (int k = 0; k < 200; k++) pend_q.push_back(rand_data());
    run_to_drain(50, 50, "rand", 5000);

    // Reset with two elements buffered mid-matrix.
    do_reset();
    for (int k = 0; k < 3; k++) pend_q.push_back(IN_W'(k));
    run_to_drain(100, 100, "pre_rst", 100);
    pend_q.push_back(IN_W'(3));
    pend_q.push_back(IN_W'(4));
    repeat (3) step(100, 0);
    check_eq("mid_pending", pend_q.size(), 0);
    do_reset();
    for (int k = 10; k < 16; k++) pend_q.push_back(IN_W'(k));
    run_to_drain(100, 100, "post_rst", 100);

    // Counter sticks at all-ones.
    do_reset();
    for (int k = 0; k < 5; k++) pend_q.push_back(32'h0001_0000);
    run_to_drain(100, 100, "cnt_stick", 100);
    check_eq("sat_stuck", sat_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
